// File: rtl/divn_ctrl_if.sv
// Divisor-request channel for divn_ctrl: requester drives cfg_valid/cfg_n,
// controller answers with cfg_ready and a one-cycle cfg_err pulse.
interface divn_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_n;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_n,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_n,
    output cfg_ready,
    output cfg_err
  );
endinterface

// File: rtl/divn_ctrl.sv
// divn_ctrl: programmable clock-enable divider. Emits div_en once per period
// of cur_n sclk cycles plus a ~50% div_phase. Divisor changes requested while
// running are held pending and applied only on a period boundary.
// Optional macro DIVN_CTRL_STAT_EN adds a 16-bit period_cnt of div_en pulses.
module divn_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_RST = 5
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic             run,
  divn_ctrl_if.slave       cfg,
  output logic [WIDTH-1:0] cur_n,
  output logic             div_en,
  output logic             div_phase,
  output logic             busy
`ifdef DIVN_CTRL_STAT_EN
  ,
  output logic [15:0]      period_cnt
`endif
);

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] cur_n_d;
  logic [WIDTH-1:0] pend_n_q, pend_n_d;

  logic             accept;
  logic             legal;
  logic             boundary;

  logic             busy_d;
  logic             ready_d;
  logic             err_d;
  logic             div_en_d;
  logic             phase_d;

  assign accept   = cfg.cfg_valid && cfg.cfg_ready;
  assign legal    = cfg.cfg_n >= WIDTH'(2);
  assign boundary = cnt_q == (cur_n - WIDTH'(1));

  // State, counter, divisor and registered outputs
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cur_n         <= WIDTH'(N_RST);
      pend_n_q      <= WIDTH'(N_RST);
      cfg.cfg_ready <= 1'b1;
      cfg.cfg_err   <= 1'b0;
      div_en        <= 1'b0;
      div_phase     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cur_n         <= cur_n_d;
      pend_n_q      <= pend_n_d;
      cfg.cfg_ready <= ready_d;
      cfg.cfg_err   <= err_d;
      div_en        <= div_en_d;
      div_phase     <= phase_d;
      busy          <= busy_d;
    end
  end

  // Next state: period counting, request capture and boundary hand-over
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cur_n_d  = cur_n;
    pend_n_d = pend_n_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept && legal) cur_n_d = cfg.cfg_n;
        if (run) state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + WIDTH'(1);
        if (accept && legal) begin
          pend_n_d = cfg.cfg_n;
          state_d  = PEND;
        end
        if (boundary) begin
          cnt_d = '0;
          // Stopping on this boundary: a request taken now is applied directly
          if (!run) begin
            state_d = IDLE;
            if (accept && legal) cur_n_d = cfg.cfg_n;
          end
        end
      end
      PEND: begin
        cnt_d = cnt_q + WIDTH'(1);
        if (boundary) begin
          cnt_d   = '0;
          cur_n_d = pend_n_q;
          state_d = run ? RUN : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output next-values derived from the next state so outputs track state exactly
  always_comb begin
    busy_d   = 1'b0;
    ready_d  = 1'b1;
    err_d    = 1'b0;
    div_en_d = 1'b0;
    phase_d  = 1'b0;
    busy_d   = state_d != IDLE;
    ready_d  = state_d != PEND;
    err_d    = accept && !legal;
    div_en_d = busy_d && (cnt_d == '0);
    phase_d  = busy_d && (cnt_d < (cur_n_d >> 1));
  end

`ifdef DIVN_CTRL_STAT_EN
  // Count emitted period pulses, free-running wrap at 16 bits
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
    end else if (div_en) begin
      period_cnt <= period_cnt + 16'd1;
    end
  end
`endif

endmodule
